// File: rtl/reduce_pkg.sv
// Shared definitions for the reduce stages: state encoding and default widths.
// The adder bench and later reduce stages use these too, so they stay in step.
package reduce_pkg;

  localparam int IN_W  = 9;
  localparam int ACC_W = 16;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/reduce_acc_add.sv
// Accumulator add with carry-out detection.
// The REDUCE_SUM_SATURATE_EN macro makes the sum clamp to all-ones on carry-out.
// Without it, the sum wraps modulo 2^ACC_W.
// Once clamped, any later nonzero add carries again, and an add of zero keeps the
// value. The clamp therefore holds for the rest of the reduction.
module reduce_acc_add
  import reduce_pkg::*;
#(
  parameter int IN_W  = reduce_pkg::IN_W,
  parameter int ACC_W = reduce_pkg::ACC_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  data,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] raw;

  // widened add, then wrap or clamp depending on build
  always_comb begin
    raw   = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, data};
    carry = raw[ACC_W];
`ifdef REDUCE_SUM_SATURATE_EN
    sum   = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
    sum   = raw[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/reduce_sum.sv
// Streaming sum-reduction stage sitting downstream of the 8-bit adder.
// It accumulates beats until in_last, then presents sum, beat count and overflow.
// The REDUCE_SUM_SATURATE_EN macro selects a saturating accumulator; the default wraps.
//
// state | meaning
// IDLE  | no partial sum held
// ACCUM | partial sum held in acc/cnt/ovf
// DONE  | result presented on out_*, input stalled
module reduce_sum
  import reduce_pkg::*;
#(
  parameter int IN_W  = reduce_pkg::IN_W,
  parameter int ACC_W = reduce_pkg::ACC_W,
  parameter int CNT_W = reduce_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_base, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_base, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic             carry, cnt_wrap, accept;

  // a first beat starts from zero, so every reduction begins fresh
  always_comb begin
    acc_base = (state == ACCUM) ? acc : '0;
    cnt_base = (state == ACCUM) ? cnt : '0;
    cnt_nxt  = cnt_base + 1'b1;
    cnt_wrap = (state == ACCUM) && (cnt == {CNT_W{1'b1}});
    ovf_nxt  = ((state == ACCUM) && ovf) || carry || cnt_wrap;
  end

  reduce_acc_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_acc_add (
    .acc   (acc_base),
    .data  (in_data),
    .sum   (acc_nxt),
    .carry (carry)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state; handshakes decode registered state only, with no out_ready -> in_ready path
  always_comb begin
    state_nxt = state;
    in_ready  = (state != DONE);
    out_valid = (state == DONE);
    accept    = in_valid && in_ready;
    case (state)
      IDLE, ACCUM: if (accept) state_nxt = in_last ? DONE : ACCUM;
      DONE:        if (out_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // running totals, plus result capture on the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      if (in_last) begin
        out_data  <= acc_nxt;
        out_count <= cnt_nxt;
        out_ovf   <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_reduce_sum.sv
// Directed bench for reduce_sum; expected values are hand-computed constants.
module tb_reduce_sum;

  localparam int IN_W  = 9;
  localparam int ACC_W = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reduce_sum #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  // The task is called 1 time unit after a rising edge. It returns 1 time unit after the
  // edge that accepted the beat.
  task automatic send_beat(input logic [IN_W-1:0] d, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_beat_timeout: in_ready=%0b, required 1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'bx;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_count, out_ovf} !== {1'b1, 1'b0, 16'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: rdy=%0b vld=%0b data=%0d cnt=%0d ovf=%0b, required 1 0 0 0 0",
               in_ready, out_valid, out_data, out_count, out_ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_beat(9'd10, 1'b0);
    send_beat(9'd20, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: out_valid=%0b, required 0", out_valid);
    end
    send_beat(9'd30, 1'b1);
    checks++;
    if ({out_valid, out_data, out_count, out_ovf} !== {1'b1, 16'd60, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: vld=%0b data=%0d cnt=%0d ovf=%0b, required 1 60 3 0",
               out_valid, out_data, out_count, out_ovf);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_done: in_ready=%0b, required 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_after_hs: vld=%0b rdy=%0b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send_beat(9'd256, 1'b1);
    checks++;
    if ({out_valid, out_data, out_count, out_ovf} !== {1'b1, 16'd256, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_result: vld=%0b data=%0d cnt=%0d ovf=%0b, required 1 256 1 0",
               out_valid, out_data, out_count, out_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(9'd100, 1'b0);
    send_beat(9'd100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 9'd50;
      in_last  = 1'b1;
      checks++;
      if ({out_valid, out_data, out_count, in_ready} !== {1'b1, 16'd200, 8'd2, 1'b0}) begin
        errors++;
        $display("FAIL stall_cycle%0d: vld=%0b data=%0d cnt=%0d rdy=%0b, required 1 200 2 0",
                 i, out_valid, out_data, out_count, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL stall_release: vld=%0b rdy=%0b, required 0 1", out_valid, in_ready);
    end
    // A beat swallowed during the stall would show up here as a wrong count or sum.
    send_beat(9'd3, 1'b1);
    checks++;
    if ({out_data, out_count} !== {16'd3, 8'd1}) begin
      errors++;
      $display("FAIL stall_not_consumed: data=%0d cnt=%0d, required 3 1", out_data, out_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    logic [ACC_W-1:0] exp_data;
`ifdef REDUCE_SUM_SATURATE_EN
    exp_data = 16'd65535;
`else
    exp_data = 16'd383;
`endif
    out_ready = 1'b1;
    for (int i = 1; i <= 129; i++) send_beat(9'd511, (i == 129));
    checks++;
    if ({out_valid, out_data, out_count, out_ovf} !== {1'b1, exp_data, 8'd129, 1'b1}) begin
      errors++;
      $display("FAIL overflow_result: vld=%0b data=%0d cnt=%0d ovf=%0b, required 1 %0d 129 1",
               out_valid, out_data, out_count, out_ovf, exp_data);
    end
    @(posedge clk); #1;
    // The sticky flag must clear for the next reduction.
    send_beat(9'd1, 1'b1);
    checks++;
    if ({out_data, out_count, out_ovf} !== {16'd1, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL overflow_clear: data=%0d cnt=%0d ovf=%0b, required 1 1 0",
               out_data, out_count, out_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_beat(9'd10, 1'b0);
    send_beat(9'd20, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_hold: vld=%0b rdy=%0b, required 0 1", out_valid, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_result: out_valid=%0b, required 0", out_valid);
    end
    send_beat(9'd5, 1'b1);
    checks++;
    if ({out_valid, out_data, out_count, out_ovf} !== {1'b1, 16'd5, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_result: vld=%0b data=%0d cnt=%0d ovf=%0b, required 1 5 1 0",
               out_valid, out_data, out_count, out_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gapped();
    out_ready = 1'b1;
    send_beat(9'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL gapped_idle: vld=%0b rdy=%0b, required 0 1", out_valid, in_ready);
    end
    send_beat(9'd8, 1'b1);
    checks++;
    if ({out_valid, out_data, out_count, out_ovf} !== {1'b1, 16'd15, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL gapped_result: vld=%0b data=%0d cnt=%0d ovf=%0b, required 1 15 2 0",
               out_valid, out_data, out_count, out_ovf);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_gapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
